// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI responder.
package spi_pkg;
    localparam int unsigned SPI_WIDTH = 8;
    localparam int unsigned CNT_W     = $clog2(SPI_WIDTH);
    localparam logic [SPI_WIDTH-1:0] FILL_BYTE = 8'hFF;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;
endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with rise/fall pulses
// derived from the synchronized value and its one-cycle-older copy.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise_c,
    output logic fall_c
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign q      = chain[SYNC_STAGES-1];
    assign rise_c = chain[SYNC_STAGES-1] & ~prev;
    assign fall_c = ~chain[SYNC_STAGES-1] & prev;
endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI responder, mode CPOL=0/CPHA=1, oversampled in the clk domain
// with a single-entry transmit holding register and a receive strobe.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss_n,
    input  logic                 sck,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 underrun
);
    logic sck_s, sck_rise_c, sck_fall_c;
    logic ss_s, ss_rise_unused, ss_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .din(sck),
        .q(sck_s), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(ss_n),
        .q(ss_s), .rise_c(ss_rise_unused), .fall_c(ss_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(mosi),
        .q(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
    );

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [SPI_WIDTH-1:0] tx_shift, tx_shift_nxt;
    logic [SPI_WIDTH-1:0] rx_shift, rx_shift_nxt;
    logic [SPI_WIDTH-1:0] hold, hold_nxt;
    logic [SPI_WIDTH-1:0] rx_data_nxt;
    logic [SPI_WIDTH-1:0] load_c;
    logic                 miso_nxt, rx_valid_nxt, tx_ready_nxt, underrun_nxt, busy_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            hold     <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_ready <= 1'b1;
            underrun <= 1'b0;
        end else begin
            bit_cnt  <= bit_cnt_nxt;
            tx_shift <= tx_shift_nxt;
            rx_shift <= rx_shift_nxt;
            hold     <= hold_nxt;
            miso     <= miso_nxt;
            miso_oe  <= busy_nxt;
            busy     <= busy_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            tx_ready <= tx_ready_nxt;
            underrun <= underrun_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        hold_nxt     = hold;
        miso_nxt     = miso;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        tx_ready_nxt = tx_ready;
        underrun_nxt = underrun;
        load_c       = FILL_BYTE;

        // Accepted write fills the holding register; a load this cycle still sees the old contents
        if (tx_valid && tx_ready) begin
            hold_nxt     = tx_data;
            tx_ready_nxt = 1'b0;
            underrun_nxt = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (!ss_s) begin
                    state_nxt   = ACTIVE;
                    bit_cnt_nxt = '0;
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end else begin
                    if (sck_rise_c) begin
                        if (bit_cnt == '0) begin
                            if (tx_ready) begin
                                underrun_nxt = 1'b1;
                            end else begin
                                load_c       = hold;
                                tx_ready_nxt = 1'b1;
                            end
                            miso_nxt     = load_c[SPI_WIDTH-1];
                            tx_shift_nxt = {load_c[SPI_WIDTH-2:0], 1'b0};
                        end else begin
                            miso_nxt     = tx_shift[SPI_WIDTH-1];
                            tx_shift_nxt = {tx_shift[SPI_WIDTH-2:0], 1'b0};
                        end
                    end
                    if (sck_fall_c) begin
                        rx_shift_nxt = {rx_shift[SPI_WIDTH-2:0], mosi_s};
                        bit_cnt_nxt  = bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(SPI_WIDTH - 1)) begin
                            rx_data_nxt  = {rx_shift[SPI_WIDTH-2:0], mosi_s};
                            rx_valid_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == ACTIVE);
    end
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-level SPI master drives frames while a
// byte-level model of the holding register predicts miso bytes, rx bytes and underrun.
module tb_spi_slave;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst, ss_n, sck, mosi, miso, miso_oe, tx_valid, tx_ready, rx_valid, busy, underrun;
    logic [7:0] tx_data, rx_data;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .underrun(underrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Byte-level model of the holding register and sticky flag
    logic       m_full, m_underrun;
    logic [7:0] m_hold, m_rx_last;

    // Per-frame stimulus and observations
    logic [7:0] f_mosi[4], f_ref[4], f_miso[4], f_exp[4];
    logic       f_en[4];
    logic       f_busy;

    logic [7:0] rx_q[$];
    int         rxv_run  = 0;
    int         rxv_long = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rxv_run++;
            if (rxv_run > 1) rxv_long++;
        end else begin
            rxv_run = 0;
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        if (!m_full) begin
            m_full     = 1'b1;
            m_hold     = b;
            m_underrun = 1'b0;
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic run_frame(input int nbytes, input int abort_bits, input bit abort_rst);
        int bits;
        bit stop;
        bits = 0;
        stop = 1'b0;
        rx_q.delete();
        @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        f_busy = busy && miso_oe;
        for (int k = 0; k < nbytes && !stop; k++) begin
            for (int i = 7; i >= 0 && !stop; i--) begin
                if (abort_bits > 0 && bits == abort_bits) begin
                    stop = 1'b1;
                end else begin
                    if (i == 7) begin
                        f_exp[k] = m_full ? m_hold : 8'hFF;
                        if (!m_full) m_underrun = 1'b1;
                        m_full = 1'b0;
                    end
                    sck  = 1'b1;
                    mosi = f_mosi[k][i];
                    for (int j = 1; j <= HALF; j++) begin
                        @(negedge clk);
                        if (i == 7 && f_en[k] && j == 4) begin
                            tx_valid   = 1'b1;
                            tx_data    = f_ref[k];
                            m_full     = 1'b1;
                            m_hold     = f_ref[k];
                            m_underrun = 1'b0;
                        end
                        if (j == 5) tx_valid = 1'b0;
                    end
                    f_miso[k][i] = miso;
                    sck = 1'b0;
                    repeat (HALF) @(negedge clk);
                    bits++;
                end
            end
        end
        if (stop && abort_rst) begin
            rst  = 1'b1;
            ss_n = 1'b1;
            @(negedge clk);
        end else begin
            ss_n = 1'b1;
            repeat (HALF) @(negedge clk);
            if (bits / 8 > 0) m_rx_last = f_mosi[bits/8-1];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++; if (miso !== 1'b0)     begin n_fail++; $display("FAIL %s_miso got %b exp 0", tag, miso); end
        n_tests++; if (miso_oe !== 1'b0)  begin n_fail++; $display("FAIL %s_miso_oe got %b exp 0", tag, miso_oe); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL %s_busy got %b exp 0", tag, busy); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL %s_rx_data got %h exp 00", tag, rx_data); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL %s_rx_valid got %b exp 0", tag, rx_valid); end
        n_tests++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL %s_tx_ready got %b exp 1", tag, tx_ready); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL %s_underrun got %b exp 0", tag, underrun); end
    endtask

    task automatic check_frame(input string tag, input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            n_tests++;
            if (f_miso[k] !== f_exp[k]) begin n_fail++; $display("FAIL %s_miso_byte%0d got %h exp %h", tag, k, f_miso[k], f_exp[k]); end
        end
        n_tests++;
        if (rx_q.size() != nbytes) begin
            n_fail++; $display("FAIL %s_rx_count got %0d exp %0d", tag, rx_q.size(), nbytes);
        end else begin
            for (int k = 0; k < nbytes; k++) begin
                n_tests++;
                if (rx_q[k] !== f_mosi[k]) begin n_fail++; $display("FAIL %s_rx_byte%0d got %h exp %h", tag, k, rx_q[k], f_mosi[k]); end
            end
        end
        n_tests++; if (underrun !== m_underrun) begin n_fail++; $display("FAIL %s_underrun got %b exp %b", tag, underrun, m_underrun); end
        n_tests++; if (tx_ready !== !m_full)    begin n_fail++; $display("FAIL %s_tx_ready got %b exp %b", tag, tx_ready, !m_full); end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 4; k++) begin
            f_en[k]   = 1'b0;
            f_ref[k]  = 8'h00;
            f_mosi[k] = 8'($urandom);
            f_miso[k] = 8'h00;
            f_exp[k]  = 8'h00;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        m_full = 1'b0; m_underrun = 1'b0; m_hold = 8'h00; m_rx_last = 8'h00;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_frame();
        write_byte(8'hA5);
        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_write_accept tx_ready got %b exp 0", tx_ready); end
        f_mosi[0] = 8'h3C;
        run_frame(1, 0, 1'b0);
        n_tests++; if (f_miso[0] !== 8'hA5) begin n_fail++; $display("FAIL basic_miso got %h exp a5", f_miso[0]); end
        n_tests++; if (f_busy !== 1'b1)     begin n_fail++; $display("FAIL basic_busy_oe got %b exp 1", f_busy); end
        check_frame("basic", 1);
    endtask

    task automatic test_underrun();
        clear_frame();
        run_frame(1, 0, 1'b0);
        n_tests++; if (f_miso[0] !== 8'hFF) begin n_fail++; $display("FAIL underrun_fill got %h exp ff", f_miso[0]); end
        n_tests++; if (underrun !== 1'b1)   begin n_fail++; $display("FAIL underrun_set got %b exp 1", underrun); end
        check_frame("underrun", 1);
        write_byte(8'h00);
        n_tests++; if (underrun !== 1'b0)   begin n_fail++; $display("FAIL underrun_clear got %b exp 0", underrun); end
    endtask

    task automatic test_back_to_back();
        clear_frame();
        run_frame(1, 0, 1'b0);
        n_tests++; if (f_miso[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_drain got %h exp 00", f_miso[0]); end
        clear_frame();
        write_byte(8'h11);
        f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_mosi[2] = 8'h03;
        f_en[0] = 1'b1; f_ref[0] = 8'h22;
        f_en[1] = 1'b1; f_ref[1] = 8'h33;
        run_frame(3, 0, 1'b0);
        n_tests++;
        if (f_miso[0] !== 8'h11 || f_miso[1] !== 8'h22 || f_miso[2] !== 8'h33) begin
            n_fail++; $display("FAIL b2b_miso got %h %h %h exp 11 22 33", f_miso[0], f_miso[1], f_miso[2]);
        end
        check_frame("b2b", 3);
    endtask

    task automatic test_abort();
        clear_frame();
        write_byte(8'($urandom));
        run_frame(1, 5, 1'b0);
        n_tests++; if (rx_q.size() != 0)      begin n_fail++; $display("FAIL abort_rx_count got %0d exp 0", rx_q.size()); end
        n_tests++; if (rx_data !== m_rx_last) begin n_fail++; $display("FAIL abort_rx_data got %h exp %h", rx_data, m_rx_last); end
        n_tests++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
        clear_frame();
        write_byte(8'($urandom));
        f_mosi[0] = 8'h81;
        run_frame(1, 0, 1'b0);
        check_frame("after_abort", 1);
    endtask

    task automatic test_overwrite();
        logic [7:0] p;
        clear_frame();
        p = 8'($urandom);
        write_byte(p);
        write_byte(8'h55);
        n_tests++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL overwrite_ready got %b exp 0", tx_ready); end
        run_frame(1, 0, 1'b0);
        n_tests++; if (f_miso[0] !== p)   begin n_fail++; $display("FAIL overwrite_kept got %h exp %h", f_miso[0], p); end
        check_frame("overwrite", 1);
    endtask

    task automatic test_reset_mid();
        clear_frame();
        write_byte(8'($urandom));
        run_frame(1, 3, 1'b1);
        check_reset_outputs("midrst");
        rst = 1'b0;
        m_full = 1'b0; m_underrun = 1'b0; m_rx_last = 8'h00;
        repeat (HALF) @(negedge clk);
        clear_frame();
        write_byte(8'($urandom));
        run_frame(1, 0, 1'b0);
        check_frame("post_rst", 1);
    endtask

    task automatic test_random();
        int nb;
        for (int it = 0; it < 4; it++) begin
            clear_frame();
            nb = int'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) begin
                f_en[k]  = 1'($urandom);
                f_ref[k] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1) write_byte(8'($urandom));
            run_frame(nb, 0, 1'b0);
            check_frame("random", nb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_overwrite();
        test_reset_mid();
        test_random();
        n_tests++; if (rxv_long != 0) begin n_fail++; $display("FAIL rx_valid_width got %0d long pulses exp 0", rxv_long); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
# spi_slave

Byte-oriented SPI responder: the peripheral-side counterpart of the team's SPI master, for FPGA logic addressed by an external or on-chip SPI initiator. It oversamples `sck`, `ss_n` and `mosi` in the `clk` domain, shifts one 8-bit MSB-first byte per frame in each direction, and exposes a valid/ready transmit holding register and a one-cycle receive strobe to user logic. The SPI mode matches the master: CPOL=0, CPHA=1, so outputs change on the `sck` rising edge and inputs are sampled on the falling edge.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `sck`, `ss_n` and `mosi`; minimum 2.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `ss_n` in 1: slave select pin, active-low, asynchronous to `clk`.
- `sck` in 1: SPI clock pin, asynchronous to `clk`.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master.
- `miso_oe` out 1: tri-state enable for the `miso` pad; equals synchronized select active.
- `tx_data` in 8: next byte to transmit.
- `tx_valid` in 1: `tx_data` offered to the holding register.
- `tx_ready` out 1: holding register empty; the write is accepted when `tx_valid && tx_ready`.
- `rx_data` out 8: last complete received byte.
- `rx_valid` out 1: one-cycle strobe; `rx_data` has been updated.
- `busy` out 1: frame in progress (synchronized `ss_n` low).
- `underrun` out 1: sticky; a byte started with the holding register empty. Cleared by `rst` or by an accepted `tx_valid`.

## Operation
- Synchronization: `sck`, `ss_n` and `mosi` each pass through `SYNC_STAGES` flops, so all three share the same latency. The edge detector compares the synchronized `sck` with its value one cycle earlier. An edge is acted on in the same cycle it is detected ("cycle E").
- The state machine has two states.
  - IDLE → ACTIVE when synchronized `ss_n` = 0. Entering ACTIVE sets `bit_cnt` = 0.
  - ACTIVE → IDLE when synchronized `ss_n` = 1. Any partial byte is discarded, `bit_cnt` clears, no `rx_valid` is issued, and `miso` is held.
- Rising edge in ACTIVE:
  - If `bit_cnt` = 0, `tx_shift` loads from the holding register and `tx_ready` is set to 1. If the holding register is empty, `tx_shift` loads `FILL_BYTE` (0xFF) and `underrun` is set.
  - `miso` takes the current MSB and `tx_shift` shifts left.
- Falling edge in ACTIVE:
  - `rx_shift` <= {`rx_shift[6:0]`, synchronized `mosi`} and `bit_cnt` increments.
  - When `bit_cnt` = 7, `rx_data` takes the completed byte, `rx_valid` pulses, and `bit_cnt` wraps to 0. The next byte therefore begins with no gap and without deasserting `ss_n`.
- Edges in IDLE are ignored.
- `tx_valid` while `tx_ready` = 0 is ignored; the holding register is not overwritten.
- A write accepted in the same cycle as a load does not bypass the holding register. The load uses the prior register contents (or the fill byte) and the new byte waits for the next byte boundary.
- A simultaneous rising `sck` edge and `ss_n` deassert: deassert wins and no shift occurs.

## Timing
- Reset values: `miso` 0, `miso_oe` 0, `busy` 0, `rx_data` 0x00, `rx_valid` 0, `tx_ready` 1, `underrun` 0, state IDLE, holding register empty.
- Pin-to-action latency is `SYNC_STAGES`+1 clk.
  - `miso` changes at the end of cycle E of a rising edge.
  - `rx_valid` is high during cycle E+1 of the 8th falling edge, for exactly 1 clk.
  - `tx_ready` rises in cycle E+1 of the first rising edge of each byte.
- `sck` high and low phases must each be ≥ `SYNC_STAGES`+3 clk, so that `miso` settles before the master samples. When driven by the team master on the same `clk`, this requires the master `CLK_DIV` ≥ 4.
- `ss_n` must stay high for ≥ `SYNC_STAGES`+1 clk between frames to be detected.
- A synchronous `rst` mid-frame forces every output to its reset value next cycle. Synchronized `ss_n` being low at reset release starts a new frame at `bit_cnt` 0.

## Structure
- Package `spi_pkg` holds `SPI_WIDTH` = 8, `FILL_BYTE` = 8'hFF, and the state enumeration (IDLE, ACTIVE).
- Sub-module `sync_edge` provides a parameterized `SYNC_STAGES` synchronizer with rise/fall pulse outputs. It is instantiated for `sck` and `ss_n`. `mosi` uses the same module with the edge outputs unused.

## Test plan
- Reset, then write 0xA5 to the holding register. Run a mode-1 frame with `mosi` = 0x3C and `CLK_DIV` 4 → `miso` bits 1,0,1,0,0,1,0,1; `rx_data` = 0x3C with one `rx_valid` pulse; `tx_ready` = 1 after the first rising edge.
- Run a frame with the holding register empty → `miso` shifts 0xFF and `underrun` = 1. Then write 0x00 → `underrun` clears.
- Run a 3-byte frame with bytes 0x11, 0x22, 0x33 queued just in time and `mosi` = 0x01, 0x02, 0x03 → three `rx_valid` pulses with matching data and no byte slip.
- Deassert `ss_n` after 5 bits → no `rx_valid` and `rx_data` unchanged. The next frame with 0x81 receives 0x81 correctly.
- Drive `tx_valid` with 0x55 while `tx_ready` = 0 → the holding register keeps its prior byte, and that prior byte is transmitted next.
- Assert `rst` mid-byte → all outputs at reset values next cycle. A subsequent frame completes normally.
